// File: rtl/spm_dma_pkg.sv
// spm_dma_pkg: FSM state encoding, default widths and SPM bus constants
// shared by the spm_dma block-copy engine and its pointer sub-module.
package spm_dma_pkg;

   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned LEN_W_DEF  = 16;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;
   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/spm_dma_ptr.sv
// spm_dma_ptr: word-address pointer, loaded at transfer start and advanced
// with modulo-2^ADDR_W wrap; ptr_inc exposes the next address for look-ahead.
module spm_dma_ptr
   import spm_dma_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              load,
   input  logic              adv,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] ptr,
   output logic [ADDR_W-1:0] ptr_inc
);

   assign ptr_inc = ptr + ADDR_W'(1);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)
         ptr <= '0;
      else if (load)
         ptr <= load_val;
      else if (adv)
         ptr <= ptr_inc;
   end

endmodule

// File: rtl/spm_dma.sv
// spm_dma: block-copy bus initiator that owns SPM port B while busy.
// Optional constant-fill mode (no reads, 1 cycle/word) under `SPM_DMA_FILL_EN.
module spm_dma
   import spm_dma_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LEN_W  = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
`ifdef SPM_DMA_FILL_EN
   input  logic             fill,
   input  logic [31:0]      fill_data,
`endif
   output logic             busy,
   output logic             done,
   output logic [31:0]      spm_addr,
   output logic             spm_as_,
   output logic             spm_rw,
   output logic [31:0]      spm_wr_data,
   input  logic [31:0]      spm_rd_data
);

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   remain_q;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W-1:0]  src_ptr, src_inc, dst_ptr, dst_inc;
   logic               as_d, rw_d, busy_d, done_d;
   logic               load, adv;
   logic               fill_start, fill_q;
   logic [31:0]        wdata;
   logic               wr_phase;
   logic               unused_bits;

`ifdef SPM_DMA_FILL_EN
   logic [31:0] fill_data_q;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         fill_q      <= 1'b0;
         fill_data_q <= '0;
      end else if (load) begin
         fill_q      <= fill;
         fill_data_q <= fill_data;
      end
   end

   assign fill_start = fill;
   assign wdata      = fill_q ? fill_data_q : spm_rd_data;
`else
   assign fill_q     = 1'b0;
   assign fill_start = 1'b0;
   assign wdata      = spm_rd_data;
`endif

   assign unused_bits = ^{src_addr[31:ADDR_W], dst_addr[31:ADDR_W], src_ptr};

   spm_dma_ptr #(.ADDR_W(ADDR_W)) u_src_ptr (
      .clk      (clk),
      .reset_   (reset_),
      .load     (load),
      .adv      (adv),
      .load_val (src_addr[ADDR_W-1:0]),
      .ptr      (src_ptr),
      .ptr_inc  (src_inc)
   );

   spm_dma_ptr #(.ADDR_W(ADDR_W)) u_dst_ptr (
      .clk      (clk),
      .reset_   (reset_),
      .load     (load),
      .adv      (adv),
      .load_val (dst_addr[ADDR_W-1:0]),
      .ptr      (dst_ptr),
      .ptr_inc  (dst_inc)
   );

   // Bus outputs are computed for the state being entered, so they are
   // registered alongside the state and line up with it cycle for cycle.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      as_d    = DISABLE_;
      rw_d    = READ;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      load    = 1'b0;
      adv     = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  load = 1'b1;
                  if (len == '0) begin
                     state_d = FIN;
                     done_d  = 1'b1;
                  end else if (fill_start) begin
                     state_d = WR;
                     busy_d  = 1'b1;
                     as_d    = ENABLE_;
                     rw_d    = WRITE;
                     addr_d  = dst_addr[ADDR_W-1:0];
                  end else begin
                     state_d = RD;
                     busy_d  = 1'b1;
                     as_d    = ENABLE_;
                     addr_d  = src_addr[ADDR_W-1:0];
                  end
               end
            end
            RD: begin
               state_d = WR;
               busy_d  = 1'b1;
               as_d    = ENABLE_;
               rw_d    = WRITE;
               addr_d  = dst_ptr;
            end
            WR: begin
               adv = 1'b1;
               if (remain_q == LEN_W'(1)) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else if (fill_q) begin
                  busy_d  = 1'b1;
                  as_d    = ENABLE_;
                  rw_d    = WRITE;
                  addr_d  = dst_inc;
               end else begin
                  state_d = RD;
                  busy_d  = 1'b1;
                  as_d    = ENABLE_;
                  addr_d  = src_inc;
               end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q  <= IDLE;
         remain_q <= '0;
         addr_q   <= '0;
         spm_as_  <= DISABLE_;
         spm_rw   <= READ;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         spm_as_  <= as_d;
         spm_rw   <= rw_d;
         busy     <= busy_d;
         done     <= done_d;
         if (load)
            remain_q <= len;
         else if (adv)
            remain_q <= remain_q - LEN_W'(1);
      end
   end

   assign spm_addr = {{(32 - ADDR_W){1'b0}}, addr_q};

   // SPM read data only arrives in the WR cycle itself, so it is forwarded
   // straight onto the write bus, qualified by the registered write strobe.
   assign wr_phase    = (spm_as_ == ENABLE_) && (spm_rw == WRITE);
   assign spm_wr_data = wr_phase ? wdata : '0;

endmodule

// File: doc/spm_dma.md
Name: spm_dma

Overview:
- Bus initiator that drives one SPM port (address, active-low strobe, read/write, write data, read data) to copy a block of words from a source to a destination region.
- Sits beside the MEM stage and owns SPM port B while busy, so the pipeline can offload block copies and clears.
- Matches the SPM's timing: synchronous write on the clock edge, and read data registered one cycle after the strobe.

Parameters:
- ADDR_W, 5: significant word-address bits. SPM depth is 2^ADDR_W. Addresses wrap modulo 2^ADDR_W; upper bits of spm_addr are driven 0.
- LEN_W, 16: width of the word-count input and the remaining-word counter.

Ports:
- clk  in  1  system clock, rising-edge
- reset_  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  terminate the transfer; effective in any busy state
- src_addr  in  32  source word address; bits [ADDR_W-1:0] used
- dst_addr  in  32  destination word address; bits [ADDR_W-1:0] used
- len  in  LEN_W  number of words; 0 is legal
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse on normal completion
- spm_addr  out  32  word address to SPM
- spm_as_  out  1  address strobe, 0 = enabled
- spm_rw  out  1  1 = READ, 0 = WRITE
- spm_wr_data  out  32  write data to SPM
- spm_rd_data  in  32  SPM registered read data

Behaviour:
- Reset values (asynchronous, while reset_=0):
  - state = IDLE; busy = 0; done = 0.
  - spm_as_ = 1 (disabled); spm_rw = READ; spm_addr = 0; spm_wr_data = 0.
  - Internal counters = 0.
- All outputs are registered.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - start=1 and len!=0: latch src, dst, len; go to RD; busy=1.
  - start=1 and len=0: go to FIN, with no SPM access.
- RD:
  - Drive spm_as_=0, spm_rw=READ, spm_addr=src_ptr.
  - Next state WR.
- WR:
  - Drive spm_as_=0, spm_rw=WRITE, spm_addr=dst_ptr, spm_wr_data=spm_rd_data. This is the data returned for the previous RD.
  - Then src_ptr++, dst_ptr++ (mod 2^ADDR_W), remain--.
  - remain==1 before the decrement: go to FIN; otherwise go to RD.
- FIN:
  - spm_as_=1, busy=0, done=1 for exactly one cycle.
  - Then IDLE.
- Throughput is 2 cycles per word. Latency from start to done is 2*len+1 cycles after the start edge (1 for len=0).
- The strobe is deasserted (spm_as_=1) in IDLE and FIN.
- start while busy or in FIN: ignored, not queued.
- abort:
  - Priority over every transition: the next state is IDLE, done stays 0, and busy drops on the next edge.
  - When abort=1 in RD, the WR for that word is not issued. Writes already committed stay in memory.
- Overlap: regions may overlap. Copy order is strictly ascending.
  - With dst=src+1, the first word propagates through the region; this is the required, documented behaviour.
- Address wrap: a pointer at 2^ADDR_W-1 increments to 0.
- len is a full LEN_W count; it is not truncated to the SPM depth. Wrapping repeats addresses.
- reset_ low mid-transfer returns all outputs to reset values immediately, with no further writes.

Optional Feature:
- Macro: SPM_DMA_FILL_EN.
- Defined:
  - Adds inputs fill (1) and fill_data (32), both latched at start.
  - When fill=1 the RD state is skipped. WR writes fill_data to each destination word (1 cycle/word), and src_addr is ignored.
  - Latency for a fill transfer is len+1.
- Undefined:
  - The fill and fill_data ports do not exist; copy-only behaviour.

Decomposition:
- Shared header head/spm_dma_head.v:
  - State encodings: IDLE, RD, WR, FIN.
  - Default ADDR_W / LEN_W.
- Use the existing stddef constants: ENABLE_/DISABLE_, READ/WRITE.
- Sub-module spm_dma_ptr: one instance per pointer, for the src and dst address pointers.
  - Load on start, increment-with-wrap on advance.
  - Keeps the FSM file purely control.

Test Plan:
- Copy, normal case: mem[0..3] preloaded with 0xA0..0xA3; start with src=0, dst=8, len=4.
  - Expect mem[8..11] = 0xA0..0xA3.
  - done pulses exactly once, 9 cycles after start; busy is high for cycles 1..8.
- Zero length: start with len=0.
  - Expect no cycle with spm_as_=0; done at +1.
- Wrap: src=30, dst=2, len=4 with ADDR_W=5.
  - Expect reads from 30, 31, 0, 1 and writes to 2, 3, 4, 5 with the matching data.
- Abort: len=8, abort asserted in the 3rd RD state.
  - Expect exactly 2 words written, done never asserted, busy=0 on the next cycle, spm_as_=1.
- Start while busy, then reset mid-transfer:
  - A second start during a transfer is ignored: only the original 4-word copy occurs.
  - reset_ asserted during WR: all outputs go to reset values asynchronously, and no write occurs at the next edge.
- Fill (SPM_DMA_FILL_EN defined): fill=1, fill_data=0xDEADBEEF, dst=16, len=3.
  - Expect mem[16..18] = 0xDEADBEEF, no READ strobes, done at +4.
